// File: rtl/sti_unpacker.sv
// Unpacks a 1024x16-bit bit-packed ROM image into a 128x128 byte-per-pixel RAM.
// Build option: define STI_BORDER_CLEAR_EN to force the outer pixel ring to background.
module sti_unpacker (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        sti_rd,
  output logic [9:0]  sti_addr,
  input  logic [15:0] sti_di,
  output logic        res_wr,
  output logic [13:0] res_addr,
  output logic [7:0]  res_do,
  output logic [14:0] fg_count
);

  // state  | meaning
  // IDLE   | waiting for start
  // RD     | ROM read strobe for current word
  // LATCH  | capture ROM word into shift register
  // WR     | write 16 pixels, one per cycle
  // DONE   | one-cycle completion pulse
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RD    = 3'd1;
  localparam logic [2:0] S_LATCH = 3'd2;
  localparam logic [2:0] S_WR    = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]  state;
  logic [9:0]  word_cnt;
  logic [3:0]  bit_idx;
  logic [15:0] shreg;
  logic        pixel;

`ifdef STI_BORDER_CLEAR_EN
  logic [6:0] row;
  logic [6:0] col;
  logic       border;

  assign row    = word_cnt[9:3];
  assign col    = {word_cnt[2:0], bit_idx};
  assign border = (row == 7'd0) || (row == 7'd127) || (col == 7'd0) || (col == 7'd127);
  assign pixel  = shreg[15] & ~border;
`else
  assign pixel  = shreg[15];
`endif

  // The shift register is consumed MSB-first, so shreg[15] is always bit (15 - bit_idx).
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      word_cnt <= 10'd0;
      bit_idx  <= 4'd0;
      shreg    <= 16'd0;
      fg_count <= 15'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_RD;
            word_cnt <= 10'd0;
            fg_count <= 15'd0;
          end
        end
        S_RD: begin
          state <= S_LATCH;
        end
        S_LATCH: begin
          shreg   <= sti_di;
          bit_idx <= 4'd0;
          state   <= S_WR;
        end
        S_WR: begin
          shreg   <= {shreg[14:0], 1'b0};
          bit_idx <= bit_idx + 4'd1;
          if (pixel) begin
            fg_count <= fg_count + 15'd1;
          end
          if (bit_idx == 4'd15) begin
            if (word_cnt == 10'd1023) begin
              state <= S_DONE;
            end else begin
              word_cnt <= word_cnt + 10'd1;
              state    <= S_RD;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);
  assign sti_rd   = (state == S_RD);
  assign res_wr   = (state == S_WR);
  assign sti_addr = word_cnt;
  assign res_addr = {word_cnt, bit_idx};
  assign res_do   = {7'd0, res_wr & pixel};

endmodule

// File: tb/tb_sti_unpacker.sv
// Randomized bench for sti_unpacker: ROM/RAM models plus a row/column image reference.
module tb_sti_unpacker;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic        sti_rd;
  logic [9:0]  sti_addr;
  logic [15:0] sti_di;
  logic        res_wr;
  logic [13:0] res_addr;
  logic [7:0]  res_do;
  logic [14:0] fg_count;

  sti_unpacker dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .sti_rd   (sti_rd),
    .sti_addr (sti_addr),
    .sti_di   (sti_di),
    .res_wr   (res_wr),
    .res_addr (res_addr),
    .res_do   (res_do),
    .fg_count (fg_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [15:0] rom [1024];
  logic [7:0]  ram [16384];
  int          wcnt [16384];
  logic [7:0]  exp_img [16384];
  int          exp_fg;

  int viol;
  int rd_cnt;
  int done_cnt;
  bit run_active = 1'b0;
  bit clr_req = 1'b0;

`ifdef STI_BORDER_CLEAR_EN
  localparam int ONES_FG = 15876;
  localparam int W5_PIX  = 0;
  localparam int ONES_PIX0 = 0;
`else
  localparam int ONES_FG = 16384;
  localparam int W5_PIX  = 1;
  localparam int ONES_PIX0 = 1;
`endif

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ROM: data valid the cycle after the read strobe
  always @(posedge clk) begin
    if (sti_rd) sti_di <= rom[sti_addr];
  end

  always @(posedge clk) begin
    if (clr_req) begin
      for (int i = 0; i < 16384; i++) begin
        ram[i]  <= 8'hAA;
        wcnt[i] <= 0;
      end
    end else if (res_wr) begin
      ram[res_addr]  <= res_do;
      wcnt[res_addr] <= wcnt[res_addr] + 1;
    end
  end

  always @(negedge clk) begin
    if (sti_rd && res_wr) viol++;
    if (res_do > 8'd1) viol++;
    if (run_active && !busy) viol++;
    if (sti_rd) begin
      if (sti_addr != rd_cnt[9:0]) viol++;
      rd_cnt++;
    end
    if (done) done_cnt++;
  end

  // Reference image addressed by (row, col): pixel col maps to word row*8 + col/16, MSB leftmost.
  task automatic build_model();
    exp_fg = 0;
    for (int r = 0; r < 128; r++) begin
      for (int c = 0; c < 128; c++) begin
        int   w;
        int   b;
        logic p;
        w = r * 8 + c / 16;
        b = 15 - (c % 16);
        p = rom[w][b];
`ifdef STI_BORDER_CLEAR_EN
        if (r == 0 || r == 127 || c == 0 || c == 127) p = 1'b0;
`endif
        exp_img[r * 128 + c] = {7'd0, p};
        exp_fg += int'(p);
      end
    end
  endtask

  task automatic clear_ram();
    clr_req = 1'b1;
    @(posedge clk);
    #1 clr_req = 1'b0;
  endtask

  task automatic run_full(input string name, input bit noisy);
    int lat;
    int img_err;
    int wc_err;
    build_model();
    clear_ram();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start      = 1'b0;
    run_active = 1'b1;
    rd_cnt     = 0;
    done_cnt   = 0;
    viol       = 0;
    lat        = -1;
    check({name, "_first_rd"}, int'(sti_rd && sti_addr == 10'd0 && fg_count == 15'd0), 1);
    for (int i = 1; i <= 20000; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
      start = noisy && ($urandom_range(0, 5) == 0);
    end
    run_active = 1'b0;
    start      = 1'b0;
    check({name, "_latency"}, lat, 18433);
    repeat (20) @(negedge clk);
    check({name, "_done_pulses"}, done_cnt, 1);
    check({name, "_idle"}, int'({busy, done}), 0);
    check({name, "_fg_count"}, int'(fg_count), exp_fg);
    check({name, "_rom_reads"}, rd_cnt, 1024);
    check({name, "_protocol"}, viol, 0);
    img_err = 0;
    wc_err  = 0;
    for (int a = 0; a < 16384; a++) begin
      if (ram[a] !== exp_img[a]) img_err++;
      if (wcnt[a] != 1) wc_err++;
    end
    check({name, "_image"}, img_err, 0);
    check({name, "_writes_per_pixel"}, wc_err, 0);
  endtask

  initial begin
    int found;
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_strobes", int'({sti_rd, res_wr}), 0);
    check("rst_sti_addr", int'(sti_addr), 0);
    check("rst_res_addr", int'(res_addr), 0);
    check("rst_res_do", int'(res_do), 0);
    check("rst_fg_count", int'(fg_count), 0);
    reset = 1'b0;

    for (int i = 0; i < 1024; i++) rom[i] = 16'hFFFF;
    run_full("ones", 1'b0);
    check("ones_fg_const", int'(fg_count), ONES_FG);
    check("ones_pix0", int'(ram[0]), ONES_PIX0);
    check("ones_pix_inner", int'(ram[129]), 1);

    for (int i = 0; i < 1024; i++) rom[i] = 16'h0000;
    rom[5] = 16'h8001;
    run_full("w5", 1'b0);
    check("w5_pix80", int'(ram[80]), W5_PIX);
    check("w5_pix95", int'(ram[95]), W5_PIX);
    check("w5_fg_const", int'(fg_count), 2 * W5_PIX);

    for (int i = 0; i < 1024; i++) rom[i] = 16'($urandom);
    clear_ram();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    run_active = 1'b1;
    done_cnt   = 0;
    found      = 0;
    for (int i = 0; i < 8000; i++) begin
      @(negedge clk);
      if (res_wr && sti_addr == 10'd300) begin
        found = 1;
        break;
      end
    end
    check("abort_reach_word300", found, 1);
    run_active = 1'b0;
    reset = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_fg_count", int'(fg_count), 0);
    check("abort_addrs", int'({sti_addr, res_addr}), 0);
    check("abort_strobes", int'({sti_rd, res_wr, done, res_do}), 0);
    reset = 1'b0;
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_start_dropped", int'(busy), 0);
    check("abort_no_done", done_cnt, 0);

    for (int i = 0; i < 1024; i++) rom[i] = 16'($urandom);
    run_full("restart", 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sti_unpacker.md
STI_UNPACKER -- requirements
Module: sti_unpacker

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with these ports: clk  input  1  rising-edge clock, sole clock of the block.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 start  input  1  one-cycle request to unpack a full image; sampled only in IDLE.
REQ-004 busy  output  1  high from the cycle after start is accepted until the done cycle, inclusive.
REQ-005 done  output  1  one-cycle pulse; the res RAM then holds the complete 128x128 binary image for the DT core.
REQ-006 sti_rd  output  1  ROM read strobe.
REQ-007 sti_addr  output  10  ROM word address, 0..1023.
REQ-008 sti_di  input  16  ROM data, valid the cycle after sti_rd; bit 15 is the leftmost pixel.
REQ-009 res_wr  output  1  RAM write strobe.
REQ-010 res_addr  output  14  RAM byte address, equal to row*128+col.
REQ-011 res_do  output  8  RAM write data, 8'd0 (background) or 8'd1 (object).
REQ-012 fg_count  output  15  number of 8'd1 bytes written in the current or last run.

Function
REQ-013 States: IDLE, RD, LATCH, WR, DONE; encoding is free.
REQ-014 IDLE: if start=1, go to RD, set the word counter to 0 and clear fg_count to 0; otherwise stay in IDLE.
REQ-015 RD (1 cycle): drive sti_rd=1 and sti_addr=word counter; go to LATCH.
REQ-016 LATCH (1 cycle): capture sti_di into a 16-bit shift register and clear the bit index to 0; sti_rd=0; go to WR.
REQ-017 WR (16 cycles, bit index 0..15), each cycle:
 - res_wr=1
 - res_addr={word counter, bit index[3:0]}
 - res_do={7'd0, pixel}, where pixel is shift register bit (15 - bit index)
 - if pixel=1, fg_count increments by 1
REQ-018 WR at bit index 15: if word counter=1023, go to DONE; otherwise increment the word counter and go to RD.
REQ-019 DONE (1 cycle): done=1, busy=1, res_wr=0; go to IDLE.
REQ-020 Outputs at their inactive value in any state not listed above: sti_rd=0, res_wr=0, res_do=0, done=0.
REQ-021 Latency: each word takes exactly 18 cycles; done is asserted exactly 18433 cycles after the start-sampling edge.
REQ-022 start while busy SHALL be ignored, with no restart and no effect on counters.
REQ-023 fg_count SHALL hold its value from DONE until the next accepted start; maximum 16384, no wrap.
REQ-024 The word counter SHALL not wrap past 1023; the 14-bit res_addr covers exactly 0..16383.
REQ-025 Exactly one res write per pixel; no RAM reads.

Reset
REQ-026 reset=1 at a clock edge SHALL force state IDLE and clear all of the following to 0:
 - word counter, bit index, shift register
 - fg_count, busy, done, sti_rd, sti_addr, res_wr, res_addr, res_do
REQ-027 Reset during a run SHALL abort the run immediately; RAM contents are then undefined and no done pulse is issued.
REQ-028 reset and start asserted in the same cycle: reset wins and start is dropped.

Configuration
REQ-029 Macro STI_BORDER_CLEAR_EN controls border clearing.
 - Defined: pixels with row = 0 or 127, or col = 0 or 127, are written as 8'd0 regardless of the ROM bit and are not counted in fg_count.
 - row = word counter[9:3]; col = {word counter[2:0], bit index}.
REQ-030 STI_BORDER_CLEAR_EN undefined: every pixel is written as its ROM bit; there is no border logic and timing is identical.

Verification
REQ-031 ROM all 16'hFFFF, macro undefined, start pulse -> 16384 writes of 8'd1, fg_count=16384, done at cycle 18433.
REQ-032 ROM all 16'hFFFF, STI_BORDER_CLEAR_EN defined -> addresses 0..127, 16256..16383 and every col 0/127 write 0; fg_count=15876.
REQ-033 ROM word 5 = 16'h8001, rest 0 -> res[80]=1, res[95]=1, all other bytes 0, fg_count=2 (macro undefined).
REQ-034 Reset asserted in the WR state of word 300, then start -> clean restart from sti_addr=0, fg_count restarts at 0, one done pulse.
REQ-035 start pulsed repeatedly during busy -> exactly one done; total cycles unchanged; fg_count unaffected.
REQ-036 Protocol check every cycle:
 - sti_rd and res_wr never both high
 - sti_addr stable through RD
 - res_do only 0 or 1
 - busy never low between accepted start and done
